axi_write_master: RTL and testbench

AXI_WRITE_MASTER -- requirements
Module: axi_write_master

---
 rtl/axi_write_master.sv | 144 ++++++++++++++
 tb/tb_axi_write_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master.sv
// rtl/axi_write_master.sv - single-beat AXI write master with request/response handshake
// Optional B-channel watchdog is compiled in with AXI_WR_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_write_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [1:0]          resp_code,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWSIZE,
  output logic [7:0]          AWLEN,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  input  logic                BVALID,
  input  logic [1:0]          BRESP,
  output logic                BREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RESP} state_t;
  state_t state;

  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  size_mask;
  logic              local_err;
  logic [DATA_W-1:0] wdata_sh;
  logic [STRB_W-1:0] strb;
  logic              aw_done;
  logic              w_done;

  // Lane placement: the byte offset within the bus word selects the lanes.
  always_comb begin
    off       = req_addr[OFF_W-1:0];
    size_mask = OFF_W'((32'd1 << req_size) - 32'd1);
    local_err = (32'(req_size) > OFF_W) || ((off & size_mask) != '0);
    wdata_sh  = req_wdata << {off, 3'b000};
    strb      = STRB_W'(((32'd1 << (32'd1 << req_size)) - 32'd1) << off);
  end

  assign aw_done   = !AWVALID || AWREADY;
  assign w_done    = !WVALID || WREADY;
  assign req_ready = (state == IDLE) && ARESETn;
  assign AWLEN     = 8'd0;
  assign WLAST     = WVALID;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= IDLE;
      AWVALID    <= 1'b0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_code  <= 2'b00;
      AWADDR     <= '0;
      AWSIZE     <= 3'd0;
      WDATA      <= '0;
      WSTRB      <= '0;
`ifdef AXI_WR_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (local_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_code  <= 2'b11;
            end else begin
              AWADDR  <= req_addr;
              AWSIZE  <= {1'b0, req_size};
              WDATA   <= wdata_sh;
              WSTRB   <= strb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= SEND;
            end
          end
        end
        SEND: begin
          // AW and W complete independently; the last one moves us on.
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            state  <= WAIT_B;
            BREADY <= 1'b1;
`ifdef AXI_WR_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT_B: begin
          if (BVALID) begin
            BREADY     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (BRESP != 2'b00);
            resp_code  <= BRESP;
            state      <= RESP;
          end
`ifdef AXI_WR_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            BREADY     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_code  <= 2'b11;
            state      <= RESP;
          end
          wd_cnt <= wd_cnt + CNT_W'(1);
`endif
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_code  <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_write_master.sv
// tb/tb_axi_write_master.sv - scoreboard bench for axi_write_master
// Define AXI_WR_TIMEOUT_EN to also exercise the B-wait watchdog.
`timescale 1ns/1ps
module tb_axi_write_master;
  localparam int TO = 8;

  logic        ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [1:0]  resp_code;
  logic        AWVALID, WVALID, WLAST, BREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE;
  logic [7:0]  AWLEN;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;

  axi_write_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_code(resp_code),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWSIZE(AWSIZE), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Slave-side driver: random or fixed ready/response behaviour.
  bit       rand_mode = 1'b0;
  bit       aw_fix = 1'b0, w_fix = 1'b0, bv_fix = 1'b0;
  bit [1:0] br_fix = 2'b00;

  always @(posedge ACLK) begin
    #2;
    if (rand_mode) begin
      AWREADY = ($urandom_range(0, 2) != 0);
      WREADY  = ($urandom_range(0, 2) != 0);
      BVALID  = ($urandom_range(0, 3) != 0);
      BRESP   = 2'($urandom_range(0, 3));
    end else begin
      AWREADY = aw_fix;
      WREADY  = w_fix;
      BVALID  = bv_fix;
      BRESP   = br_fix;
    end
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;
  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } resp_t;

  beat_t exp_aw[$];
  beat_t exp_w[$];
  resp_t exp_resp[$];

  // Reference model: a request is illegal if the byte offset is not a
  // multiple of its size; otherwise bytes land at lanes off..off+n-1.
  task automatic model_push(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    beat_t b;
    resp_t r;
    int off, nb;
    off = int'(a % 8);
    nb  = 1 << s;
    if ((off % nb) != 0 || nb > 8) begin
      r.err = 1'b1; r.code = 2'b11;
      exp_resp.push_back(r);
    end else begin
      b.addr = a; b.size = {1'b0, s}; b.data = '0; b.strb = '0;
      for (int i = 0; i < 8; i++) begin
        if (i >= off) b.data[8*i +: 8] = d[8*(i-off) +: 8];
        if (i >= off && i < off + nb) b.strb[i] = 1'b1;
      end
      exp_aw.push_back(b);
      exp_w.push_back(b);
    end
  endtask

  int wb_cnt = 0, bh_cnt = 0, wb_entries = 0, resp_cnt = 0;
  bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_rst = 0, p_bready = 0;
  logic [31:0] p_awaddr = '0;
  logic [63:0] p_wdata = '0;
  logic [7:0]  p_wstrb = '0;

  // Monitor: pops expectations whenever the DUT presents a handshake or response.
  always @(negedge ACLK) begin
    beat_t b;
    resp_t r;
    if (p_rst && ARESETn) begin
      if (p_awv && !p_awr) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      if (p_wv && !p_wr) begin
        check("w_hold_data", WDATA, p_wdata);
        check("w_hold_strb", {WVALID, WSTRB}, {1'b1, p_wstrb});
      end
    end
    if (AWVALID === 1'b1 && AWREADY) begin
      check("aw_expected", exp_aw.size() != 0, 1);
      if (exp_aw.size() != 0) begin
        b = exp_aw.pop_front();
        check("awaddr", AWADDR, b.addr);
        check("awsize_len", {AWSIZE, AWLEN}, {b.size, 8'd0});
      end
    end
    if (WVALID === 1'b1 && WREADY) begin
      check("w_expected", exp_w.size() != 0, 1);
      if (exp_w.size() != 0) begin
        b = exp_w.pop_front();
        check("wdata", WDATA, b.data);
        check("wstrb_wlast", {WSTRB, WLAST}, {b.strb, 1'b1});
      end
    end
    if (BREADY === 1'b1) begin
      check("bready_alone", {AWVALID, WVALID}, 2'b00);
      if (!p_bready) wb_entries++;
      if (BVALID) begin
        bh_cnt++;
        r.err = (BRESP != 2'b00); r.code = BRESP;
        exp_resp.push_back(r);
        wb_cnt = 0;
      end else begin
        wb_cnt++;
`ifdef AXI_WR_TIMEOUT_EN
        if (wb_cnt == TO) begin
          r.err = 1'b1; r.code = 2'b11;
          exp_resp.push_back(r);
          wb_cnt = 0;
        end
`endif
      end
    end else begin
      wb_cnt = 0;
    end
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      check("resp_expected", exp_resp.size() != 0, 1);
      if (exp_resp.size() != 0) begin
        r = exp_resp.pop_front();
        check("resp", {resp_err, resp_code}, {r.err, r.code});
      end
    end
    p_awv = (AWVALID === 1'b1); p_awr = AWREADY;
    p_wv = (WVALID === 1'b1);   p_wr = WREADY;
    p_rst = ARESETn; p_bready = (BREADY === 1'b1);
    p_awaddr = AWADDR; p_wdata = WDATA; p_wstrb = WSTRB;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge ACLK);
      if (req_ready === 1'b1) ok = 1'b1;
      @(posedge ACLK); #1;
    end
    req_valid = 1'b0;
    check("req_accepted", ok, 1);
    if (ok) model_push(a, s, d);
  endtask

  task automatic wait_resp(output int n, output int nb, output bit act);
    bit got;
    got = 1'b0; n = 0; nb = 0; act = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge ACLK);
      n++;
      if (BREADY === 1'b1) nb++;
      if (AWVALID === 1'b1 || WVALID === 1'b1) act = 1'b1;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    check("resp_arrived", got, 1);
  endtask

  initial begin
    int n, nb, r0, b0, e0;
    bit act;
    logic [31:0] a;
    logic [1:0]  s;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {AWVALID, WVALID, BREADY, resp_valid, resp_err, resp_code}, 0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("ready_after_rst", req_ready, 1);
    @(posedge ACLK); #1;

    // Aligned word in the upper half of the bus, everything ready.
    aw_fix = 1; w_fix = 1; bv_fix = 1; br_fix = 2'b00;
    @(posedge ACLK); #1;
    issue(32'h8000_0004, 2'd2, 64'hDEAD_BEEF);
    check("r21_wstrb", WSTRB, 8'hF0);
    check("r21_wdata", WDATA, 64'hDEAD_BEEF_0000_0000);
    wait_resp(n, nb, act);
    check("r21_latency", n, 3);
    check("r21_err", resp_err, 0);
    @(posedge ACLK); #1;

    // W completes first, AW three cycles later.
    aw_fix = 0; w_fix = 1; bv_fix = 1;
    r0 = resp_cnt; b0 = bh_cnt; e0 = wb_entries;
    @(posedge ACLK); #1;
    issue(32'h0000_1230, 2'd3, 64'h0123_4567_89AB_CDEF);
    @(negedge ACLK);
    @(negedge ACLK);
    check("r22_w_first", {AWVALID, WVALID}, 2'b10);
    repeat (2) @(posedge ACLK);
    #1 aw_fix = 1;
    wait_resp(n, nb, act);
    @(posedge ACLK); #1;
    check("r22_one_resp", resp_cnt - r0, 1);
    check("r22_one_bhs", bh_cnt - b0, 1);
    check("r22_one_waitb", wb_entries - e0, 1);

    // Misaligned halfword: local error, no bus activity.
    issue(32'h8000_0003, 2'd1, 64'h0000_0000_0000_ABCD);
    wait_resp(n, nb, act);
    check("r23_latency", n, 1);
    check("r23_resp", {resp_err, resp_code}, 3'b111);
    check("r23_no_bus", act, 0);
    @(posedge ACLK); #1;

    // Slave error propagates.
    br_fix = 2'b10;
    @(posedge ACLK); #1;
    issue(32'h0000_0010, 2'd2, 64'h0000_0000_1111_2222);
    wait_resp(n, nb, act);
    check("r24_resp", {resp_err, resp_code}, 3'b110);
    @(posedge ACLK); #1;
    br_fix = 2'b00;

    // Reset while stalled in SEND abandons the transaction.
    aw_fix = 0; w_fix = 0;
    @(posedge ACLK); #1;
    r0 = resp_cnt;
    issue(32'h0000_0008, 2'd3, 64'hCAFE_F00D_1234_5678);
    @(negedge ACLK);
    check("r25_in_send", {AWVALID, WVALID}, 2'b11);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("r25_valids_dropped", {AWVALID, WVALID, req_ready}, 3'b000);
    exp_aw.delete();
    exp_w.delete();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    aw_fix = 1; w_fix = 1;
    @(negedge ACLK);
    check("r25_ready_after", req_ready, 1);
    repeat (5) @(negedge ACLK);
    check("r25_no_resp", resp_cnt - r0, 0);
    @(posedge ACLK); #1;

    // Randomized traffic against the reference model.
    rand_mode = 1'b1;
    for (int k = 0; k < 150; k++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << s) - 32'd1);
      issue(a, s, {$urandom, $urandom});
      wait_resp(n, nb, act);
      @(posedge ACLK); #1;
    end
    rand_mode = 1'b0;
    aw_fix = 1; w_fix = 1; bv_fix = 1;
    repeat (2) @(posedge ACLK); #1;

`ifdef AXI_WR_TIMEOUT_EN
    bv_fix = 0;
    @(posedge ACLK); #1;
    issue(32'h0000_0040, 2'd2, 64'h0000_0000_5555_AAAA);
    wait_resp(n, nb, act);
    check("r26_waitb_cycles", nb, TO);
    check("r26_resp", {resp_err, resp_code}, 3'b111);
    @(posedge ACLK); #1;
    bv_fix = 1;
`endif

    repeat (3) @(negedge ACLK);
    check("aw_queue_drained", exp_aw.size(), 0);
    check("w_queue_drained", exp_w.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
